alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: writes one ALU result back to register A or D and updates the
// condition flags once the ALU output has had time to settle.
//
// Sequence for one request:
//   IDLE   -- waits for start; captures dest_sel and loads the settle counter
//   SETTLE -- lasts exactly SETTLE_CYCLES cycles while alu_result settles
//   LATCH  -- on the edge that leaves this state the destination register and
//             the flags are loaded from the ALU outputs
//   DONE   -- done is high for this single cycle, then back to IDLE
//
// Parameters:
//   SETTLE_CYCLES  settle time in cycles, legal range 1..15 (default 3)
//
// Optional feature:
//   ALU_SIGN_FLAG_EN  when defined, flag_sign is a real flag loaded from
//                     alu_result[7]; when undefined, flag_sign is tied to 0
//                     and has no storage.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   request one write-back (honoured only in IDLE)
//   dest_sel    in   destination: 0 = reg_a, 1 = reg_d (sampled with start)
//   alu_result  in   8-bit ALU result (sampled only at the LATCH edge)
//   alu_carry   in   ALU carry out (sampled only at the LATCH edge)
//   alu_zero    in   ALU zero detect (sampled only at the LATCH edge)
//   busy        out  high in SETTLE and LATCH
//   done        out  one-cycle pulse after the update
//   reg_a       out  register A
//   reg_d       out  register D
//   flag_carry  out  carry flag
//   flag_zero   out  zero flag
//   flag_sign   out  sign flag (0 when ALU_SIGN_FLAG_EN is undefined)

module alu_writeback #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dest_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       busy,
  output logic       done,
  output logic [7:0] reg_a,
  output logic [7:0] reg_d,
  output logic       flag_carry,
  output logic       flag_zero,
  output logic       flag_sign
);

  // Counter counts down to zero, so SETTLE lasts SETTLE_CYCLES cycles.
  localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StLatch,
    StDone
  } state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       dest_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      dest_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reg_a      <= 8'h00;
      reg_d      <= 8'h00;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
`ifdef ALU_SIGN_FLAG_EN
      flag_sign  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dest_q  <= dest_sel;
            cnt_q   <= CntLoad;
            busy    <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == 4'd0) begin
            state_q <= StLatch;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StLatch: begin
          if (dest_q) begin
            reg_d <= alu_result;
          end else begin
            reg_a <= alu_result;
          end
          flag_carry <= alu_carry;
          flag_zero  <= alu_zero;
`ifdef ALU_SIGN_FLAG_EN
          flag_sign  <= alu_result[7];
`endif
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          // start is deliberately ignored here; nothing is queued.
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifndef ALU_SIGN_FLAG_EN
  assign flag_sign = 1'b0;
`endif

`ifndef SYNTHESIS
  busy_done_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(busy && done));
`endif

endmodule
